// File: rtl/execute_unit_mc_pkg.sv
// Shared encodings for the multi-cycle execute stage: ALU ops, unit/mode selects, FSM states.
package execute_unit_mc_pkg;

    localparam int WORD = 64;

    typedef enum logic [3:0] {
        ALU_AND    = 4'b0000,
        ALU_ORR    = 4'b0001,
        ALU_ADD    = 4'b0010,
        ALU_EOR    = 4'b0011,
        ALU_LSL    = 4'b0100,
        ALU_LSR    = 4'b0101,
        ALU_SUB    = 4'b0110,
        ALU_PASS_B = 4'b0111,
        ALU_NOR    = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        UNIT_ALU  = 2'b00,
        UNIT_MUL  = 2'b01,
        UNIT_DIV  = 2'b10,
        UNIT_RSVD = 2'b11
    } unit_sel_e;

    localparam logic [1:0] MD_MUL   = 2'b00;
    localparam logic [1:0] MD_UMULH = 2'b01;
    localparam logic [1:0] MD_SMULH = 2'b10;
    localparam logic [1:0] MD_UDIV  = 2'b00;
    localparam logic [1:0] MD_SDIV  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ITER = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/execute_unit_mc_if.sv
// Operation/result handshake bundle between register-read, execute and memory stages.
interface execute_unit_mc_if import execute_unit_mc_pkg::*; #(
    parameter int WIDTH = WORD
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] rs1;
    logic [WIDTH-1:0] rs2;
    logic             alu_src;
    logic [3:0]       alu_op;
    logic [1:0]       unit_sel;
    logic [1:0]       md_mode;
    logic             update_sreg;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;

    modport master (
        output in_valid, pc, imm, rs1, rs2, alu_src, alu_op, unit_sel, md_mode, update_sreg, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, pc, imm, rs1, rs2, alu_src, alu_op, unit_sel, md_mode, update_sreg, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/execute_unit_mc_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider on magnitudes, sign fixed up on the way out.
// One step per cycle for WIDTH cycles after start; done pulses on the final step, res valid the cycle after.
module execute_unit_mc_iter_muldiv import execute_unit_mc_pkg::*; #(
    parameter int WIDTH  = WORD,
    parameter bit DIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             abort,
    input  logic             start,
    input  logic             div,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hi, lo, bmag;
    logic               is_div, neg, sel_hi, div0;
    logic               do_div, sgn_mode, sgn_a, sgn_b;
    logic [WIDTH-1:0]   amag, bmag_in, quo;
    logic [WIDTH:0]     mul_sum, div_rem, div_diff;
    logic [2*WIDTH-1:0] prod, prod_s;

    assign do_div   = DIV_EN && div;
    assign sgn_mode = do_div ? (mode == MD_SDIV) : (mode == MD_SMULH);
    assign sgn_a    = sgn_mode && a[WIDTH-1];
    assign sgn_b    = sgn_mode && b[WIDTH-1];
    assign amag     = sgn_a ? -a : a;
    assign bmag_in  = sgn_b ? -b : b;

    // hi:lo doubles as product accumulator (mul) or remainder:dividend/quotient (div).
    assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, bmag} : '0);
    assign div_rem  = {hi, lo[WIDTH-1]};
    assign div_diff = div_rem - {1'b0, bmag};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            bmag   <= '0;
            is_div <= 1'b0;
            neg    <= 1'b0;
            sel_hi <= 1'b0;
            div0   <= 1'b0;
        end else if (abort) begin
            cnt <= '0;
        end else if (start) begin
            cnt    <= CNT_W'(WIDTH);
            hi     <= '0;
            lo     <= amag;
            bmag   <= bmag_in;
            is_div <= do_div;
            neg    <= sgn_a ^ sgn_b;
            sel_hi <= !do_div && (mode == MD_UMULH || mode == MD_SMULH);
            div0   <= (b == '0);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (is_div) begin
                if (!div_diff[WIDTH]) begin
                    hi <= div_diff[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], 1'b1};
                end else begin
                    hi <= div_rem[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                hi <= mul_sum[WIDTH:1];
                lo <= {mul_sum[0], lo[WIDTH-1:1]};
            end
        end
    end

    assign done   = (cnt == CNT_W'(1));
    assign prod   = {hi, lo};
    assign prod_s = neg ? -prod : prod;
    assign quo    = neg ? -lo : lo;
    // Divide by zero reports 0; MIN / -1 wraps back to MIN through the negate.
    assign res    = is_div ? (div0 ? '0 : quo)
                           : (sel_hi ? prod_s[2*WIDTH-1:WIDTH] : prod_s[WIDTH-1:0]);

endmodule

// File: rtl/execute_unit_mc.sv
// Execute stage: 1-cycle ALU with NZCV, WIDTH+2-cycle mul/div; result held in DONE until out_ready.
// in_ready only in IDLE or on the DONE handoff cycle (zero-bubble back-to-back); flush drops everything.
module execute_unit_mc import execute_unit_mc_pkg::*; #(
    parameter int WIDTH  = WORD,
    parameter bit DIV_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    execute_unit_mc_if.slave  bus,
    output logic [WIDTH-1:0]  branch_target,
    output logic              negative,
    output logic              zero,
    output logic              carry,
    output logic              overflow,
    output logic              stall
);
    localparam int SH_W = $clog2(WIDTH);

    state_e           state, state_nxt;
    logic             accept, is_mul, is_div, is_div_sel;
    logic             load_alu, load_md, start_md, md_done;
    logic             alu_c, alu_v;
    logic [WIDTH-1:0] op_b, alu_res, md_res, result_q;
    logic [WIDTH:0]   add_full, sub_full;

    assign op_b       = bus.alu_src ? bus.imm : bus.rs2;
    assign bus.in_ready = (state == ST_IDLE) || (state == ST_DONE && bus.out_ready);
    assign accept     = bus.in_valid && bus.in_ready;
    assign stall      = bus.in_valid && !bus.in_ready;
    assign is_mul     = (bus.unit_sel == UNIT_MUL);
    assign is_div_sel = (bus.unit_sel == UNIT_DIV);
    assign is_div     = DIV_EN && is_div_sel;

    assign add_full = {1'b0, bus.rs1} + {1'b0, op_b};
    // a + ~b + 1: carry out is the no-borrow flag.
    assign sub_full = {1'b0, bus.rs1} + {1'b0, ~op_b} + (WIDTH+1)'(1);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.alu_op)
            ALU_AND:    alu_res = bus.rs1 & op_b;
            ALU_ORR:    alu_res = bus.rs1 | op_b;
            ALU_EOR:    alu_res = bus.rs1 ^ op_b;
            ALU_LSL:    alu_res = bus.rs1 << op_b[SH_W-1:0];
            ALU_LSR:    alu_res = bus.rs1 >> op_b[SH_W-1:0];
            ALU_PASS_B: alu_res = op_b;
            ALU_NOR:    alu_res = ~(bus.rs1 | op_b);
            ALU_ADD: begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_v   = (bus.rs1[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.rs1[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = sub_full[WIDTH-1:0];
                alu_c   = sub_full[WIDTH];
                alu_v   = (bus.rs1[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.rs1[WIDTH-1]);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        load_alu  = 1'b0;
        load_md   = 1'b0;
        start_md  = 1'b0;
        case (state)
            ST_ITER: if (md_done) state_nxt = ST_FIX;
            ST_FIX: begin
                state_nxt = ST_DONE;
                load_md   = 1'b1;
            end
            ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
            default: ;
        endcase
        if (accept) begin
            if (is_mul || is_div) begin
                state_nxt = ST_ITER;
                start_md  = 1'b1;
            end else begin
                state_nxt = ST_DONE;
                load_alu  = 1'b1;
            end
        end
        if (flush) begin
            state_nxt = ST_IDLE;
            load_alu  = 1'b0;
            load_md   = 1'b0;
            start_md  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            result_q <= '0;
            negative <= 1'b0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_alu)
                result_q <= is_div_sel ? '0 : alu_res;
            else if (load_md)
                result_q <= md_res;
            // A DIV op completing through the ALU path (no divider) leaves the flags alone.
            if (load_alu && bus.update_sreg && !is_div_sel) begin
                negative <= alu_res[WIDTH-1];
                zero     <= (alu_res == '0);
                carry    <= alu_c;
                overflow <= alu_v;
            end
        end
    end

    execute_unit_mc_iter_muldiv #(.WIDTH(WIDTH), .DIV_EN(DIV_EN)) u_muldiv (
        .clk   (clk),
        .reset (reset),
        .abort (flush),
        .start (start_md),
        .div   (is_div),
        .mode  (bus.md_mode),
        .a     (bus.rs1),
        .b     (op_b),
        .done  (md_done),
        .res   (md_res)
    );

    assign bus.out_valid = (state == ST_DONE);
    assign bus.result    = result_q;
    assign branch_target = bus.pc + (bus.imm << 2);

endmodule
